uart_cmd_rx: RTL and testbench

UART_CMD_RX -- requirements
Module: uart_cmd_rx

---
 rtl/robot_cmd_pkg.sv | 53 +++++
 rtl/cmd_fifo.sv | 76 +++++++
 rtl/uart_cmd_rx.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_rx.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/robot_cmd_pkg.sv
// Shared types and constants for the robot command path: command encodings, ASCII
// command letters and the UART receiver state enum (RX_PARITY exists only with UART_CMD_RX_PARITY_EN).
package robot_cmd_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_STOP  = 3'd0;
    localparam cmd_t CMD_FWD   = 3'd1;
    localparam cmd_t CMD_BACK  = 3'd2;
    localparam cmd_t CMD_LEFT  = 3'd3;
    localparam cmd_t CMD_RIGHT = 3'd4;
    localparam cmd_t CMD_CAL   = 3'd5;

    localparam logic [7:0] ASCII_S = 8'h53;
    localparam logic [7:0] ASCII_F = 8'h46;
    localparam logic [7:0] ASCII_B = 8'h42;
    localparam logic [7:0] ASCII_L = 8'h4C;
    localparam logic [7:0] ASCII_R = 8'h52;
    localparam logic [7:0] ASCII_C = 8'h43;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
`ifdef UART_CMD_RX_PARITY_EN
        , RX_PARITY
`endif
    } rx_state_t;

    typedef struct packed {
        logic ok;
        cmd_t cmd;
    } dec_t;

    function automatic dec_t decode_cmd(input logic [7:0] b);
        dec_t r;
        r.ok  = 1'b1;
        r.cmd = CMD_STOP;
        case (b)
            ASCII_S: r.cmd = CMD_STOP;
            ASCII_F: r.cmd = CMD_FWD;
            ASCII_B: r.cmd = CMD_BACK;
            ASCII_L: r.cmd = CMD_LEFT;
            ASCII_R: r.cmd = CMD_RIGHT;
            ASCII_C: r.cmd = CMD_CAL;
            default: r.ok  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small command FIFO: head is read straight from the storage registers, simultaneous
// push/pop always both succeed, and a push into a full FIFO is dropped with an overflow pulse.
module cmd_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign valid    = (count_q != '0);
    assign head     = mem_q[rd_ptr_q];
    assign overflow = overflow_q;
    assign full     = (count_q == FULL_COUNT);
    assign do_pop   = pop_ready && valid;
    assign do_push  = push && (!full || do_pop);

    // When full with a pop, wr_ptr equals rd_ptr: the head is read this cycle and overwritten at the edge.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = push && full && !do_pop;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// UART receiver that turns single ASCII letters into queued drive commands.
// Default frame is 8N1; defining UART_CMD_RX_PARITY_EN switches to 8E1 with a parity check.
import robot_cmd_pkg::*;

module uart_cmd_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       uart_in,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       bad_cmd,
    output logic       overflow
);

    localparam int BIT_CYC = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W   = $clog2(BIT_CYC + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYC - 1);

    rx_state_t        state_q, state_d;
    logic             sync1_q, sync2_q, line_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             byte_done_q, byte_done_d;
    logic             frame_err_q, frame_err_d;
    logic             bad_cmd_q, bad_cmd_d;
    logic             push_q, push_d;
    cmd_t             push_cmd_q, push_cmd_d;
    logic             half_tick, full_tick;
    dec_t             dec;
`ifdef UART_CMD_RX_PARITY_EN
    logic             parity_ok;
    assign parity_ok = ~^{shift_q, sync2_q};
`endif

    assign half_tick = (cnt_q == HALF_LAST);
    assign full_tick = (cnt_q == FULL_LAST);

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync1_q     <= uart_in;
            sync2_q     <= sync1_q;
            line_prev_q <= sync2_q;
        end
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (line_prev_q && !sync2_q) state_d = RX_START;
            RX_START: if (half_tick) state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (full_tick && bit_idx_q == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                    state_d = RX_PARITY;
`else
                    state_d = RX_STOP;
`endif
                end
            end
`ifdef UART_CMD_RX_PARITY_EN
            RX_PARITY: if (full_tick) state_d = parity_ok ? RX_STOP : RX_WAIT_IDLE;
`endif
            RX_STOP:      if (full_tick) state_d = sync2_q ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (full_tick && sync2_q) state_d = RX_IDLE;
            default:      state_d = RX_IDLE;
        endcase
    end

    // In WAIT_IDLE the counter only advances while the line is high, so a break holds us there.
    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
            end
            RX_START: if (half_tick) cnt_d = '0;
            RX_DATA: begin
                if (full_tick) begin
                    cnt_d     = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
`ifdef UART_CMD_RX_PARITY_EN
            RX_PARITY: begin
                if (full_tick) begin
                    cnt_d       = '0;
                    frame_err_d = !parity_ok;
                end
            end
`endif
            RX_STOP: begin
                if (full_tick) begin
                    cnt_d = '0;
                    if (sync2_q) begin
                        rx_byte_d   = shift_q;
                        byte_done_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            RX_WAIT_IDLE: cnt_d = sync2_q ? cnt_q + CNT_W'(1) : '0;
            default:      cnt_d = '0;
        endcase
    end

    always_comb begin
        dec        = decode_cmd(rx_byte_q);
        push_d     = byte_done_q && dec.ok;
        push_cmd_d = dec.cmd;
        bad_cmd_d  = byte_done_q && !dec.ok;
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            bad_cmd_q   <= 1'b0;
            push_q      <= 1'b0;
            push_cmd_q  <= CMD_STOP;
        end else begin
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
            bad_cmd_q   <= bad_cmd_d;
            push_q      <= push_d;
            push_cmd_q  <= push_cmd_d;
        end
    end

    cmd_fifo #(
        .WIDTH(3),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_50),
        .reset     (reset),
        .push      (push_q),
        .push_data (push_cmd_q),
        .pop_ready (cmd_ready),
        .head      (cmd),
        .valid     (cmd_valid),
        .overflow  (overflow)
    );

    assign rx_byte   = rx_byte_q;
    assign frame_err = frame_err_q;
    assign bad_cmd   = bad_cmd_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: serial frames are bit-banged on uart_in and a negedge
// monitor tallies pulses and popped commands; honours UART_CMD_RX_PARITY_EN when defined.
module tb_uart_cmd_rx;

    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD    = 115200;
    localparam int BIT_CYC = 434;

    logic       clk_50 = 1'b0;
    logic       reset;
    logic       uart_in;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       bad_cmd;
    logic       overflow;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    int frameErrTotal = 0;
    int badCmdTotal = 0;
    int overflowTotal = 0;
    int validCycles = 0;
    int popCount = 0;
    logic [2:0] popLog [32];

    uart_cmd_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_50    (clk_50),
        .reset     (reset),
        .uart_in   (uart_in),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .bad_cmd   (bad_cmd),
        .overflow  (overflow)
    );

    always #10 clk_50 = ~clk_50;

    // Negedge monitor: a pop is seen the half cycle before the edge that performs it.
    always @(negedge clk_50) begin
        if (frame_err) frameErrTotal++;
        if (bad_cmd) badCmdTotal++;
        if (overflow) overflowTotal++;
        if (cmd_valid) validCycles++;
        if (cmd_valid && cmd_ready && !reset) begin
            if (popCount < 32) popLog[popCount] = cmd;
            popCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic sendBit(input logic b);
        uart_in = b;
        repeat (BIT_CYC) @(posedge clk_50);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit stopHigh, input bit parityGood);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(data[i]);
`ifdef UART_CMD_RX_PARITY_EN
        sendBit(parityGood ? ^data : ~^data);
`endif
        sendBit(stopHigh);
        uart_in = 1'b1;
        repeat (stopHigh ? BIT_CYC : 2 * BIT_CYC) @(posedge clk_50);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        @(negedge clk_50);
        checkOutput({tag, "_cmd"}, 32'(cmd), 32'd0);
        checkOutput({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        checkOutput({tag, "_rx_byte"}, 32'(rx_byte), 32'd0);
        checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        checkOutput({tag, "_bad_cmd"}, 32'(bad_cmd), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        int fe0, bc0, ov0, vc0, pc0;

        reset = 1'b1;
        uart_in = 1'b1;
        cmd_ready = 1'b0;
        repeat (5) @(posedge clk_50);
        checkResetOutputs("reset");
        @(posedge clk_50); #1;
        reset = 1'b0;
        cmd_ready = 1'b1;
        repeat (20) @(posedge clk_50); #1;

        $display("[TB] single F frame");
        fe0 = frameErrTotal; bc0 = badCmdTotal; ov0 = overflowTotal; vc0 = validCycles; pc0 = popCount;
        applyStimulus(8'h46, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("f_rx_byte", 32'(rx_byte), 32'h46);
        checkOutput("f_pops", 32'(popCount - pc0), 32'd1);
        checkOutput("f_cmd", 32'(popLog[pc0]), 32'd1);
        checkOutput("f_valid_cycles", 32'(validCycles - vc0), 32'd1);
        checkOutput("f_no_pulses", 32'((frameErrTotal - fe0) + (badCmdTotal - bc0) + (overflowTotal - ov0)), 32'd0);

        $display("[TB] 100 ns glitch");
        fe0 = frameErrTotal; bc0 = badCmdTotal; ov0 = overflowTotal; vc0 = validCycles; pc0 = popCount;
        uart_in = 1'b0;
        #100;
        uart_in = 1'b1;
        repeat (2 * BIT_CYC) @(posedge clk_50);
        @(negedge clk_50);
        checkOutput("glitch_rx_byte", 32'(rx_byte), 32'h46);
        checkOutput("glitch_valid_cycles", 32'(validCycles - vc0), 32'd0);
        checkOutput("glitch_no_pulses", 32'((frameErrTotal - fe0) + (badCmdTotal - bc0) + (overflowTotal - ov0)), 32'd0);

        $display("[TB] framing error then S");
        fe0 = frameErrTotal; pc0 = popCount;
        applyStimulus(8'h46, 1'b0, 1'b1);
        @(negedge clk_50);
        checkOutput("ferr_pulses", 32'(frameErrTotal - fe0), 32'd1);
        checkOutput("ferr_pops", 32'(popCount - pc0), 32'd0);
        checkOutput("ferr_rx_byte", 32'(rx_byte), 32'h46);
        applyStimulus(8'h53, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("s_pops", 32'(popCount - pc0), 32'd1);
        checkOutput("s_cmd", 32'(popLog[pc0]), 32'd0);
        checkOutput("s_rx_byte", 32'(rx_byte), 32'h53);

        $display("[TB] overflow with stalled consumer");
        @(posedge clk_50); #1;
        cmd_ready = 1'b0;
        ov0 = overflowTotal; pc0 = popCount;
        applyStimulus(8'h46, 1'b1, 1'b1);
        applyStimulus(8'h42, 1'b1, 1'b1);
        applyStimulus(8'h4C, 1'b1, 1'b1);
        applyStimulus(8'h52, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("full_no_overflow", 32'(overflowTotal - ov0), 32'd0);
        applyStimulus(8'h53, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("ovf_pulses", 32'(overflowTotal - ov0), 32'd1);
        checkOutput("ovf_head_valid", 32'(cmd_valid), 32'd1);
        checkOutput("ovf_head_cmd", 32'(cmd), 32'd1);
        @(posedge clk_50); #1;
        cmd_ready = 1'b1;
        repeat (10) @(posedge clk_50);
        @(negedge clk_50);
        checkOutput("drain_pops", 32'(popCount - pc0), 32'd4);
        checkOutput("drain_0", 32'(popLog[pc0]), 32'd1);
        checkOutput("drain_1", 32'(popLog[pc0 + 1]), 32'd2);
        checkOutput("drain_2", 32'(popLog[pc0 + 2]), 32'd3);
        checkOutput("drain_3", 32'(popLog[pc0 + 3]), 32'd4);
        checkOutput("drain_empty", 32'(cmd_valid), 32'd0);

        $display("[TB] unknown byte X");
        bc0 = badCmdTotal; vc0 = validCycles;
        applyStimulus(8'h58, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("x_bad_cmd", 32'(badCmdTotal - bc0), 32'd1);
        checkOutput("x_rx_byte", 32'(rx_byte), 32'h58);
        checkOutput("x_valid_cycles", 32'(validCycles - vc0), 32'd0);

        $display("[TB] reset during data bit 4");
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b0);
        uart_in = 1'b0;
        repeat (200) @(posedge clk_50); #1;
        reset = 1'b1;
        uart_in = 1'b1;
        repeat (3) @(posedge clk_50);
        checkResetOutputs("midreset");
        @(posedge clk_50); #1;
        reset = 1'b0;
        repeat (2 * BIT_CYC) @(posedge clk_50); #1;
        fe0 = frameErrTotal; vc0 = validCycles; pc0 = popCount;
`ifdef UART_CMD_RX_PARITY_EN
        applyStimulus(8'h43, 1'b1, 1'b0);
        @(negedge clk_50);
        checkOutput("c_parity_ferr", 32'(frameErrTotal - fe0), 32'd1);
        checkOutput("c_parity_pops", 32'(popCount - pc0), 32'd0);
        checkOutput("c_parity_rx_byte", 32'(rx_byte), 32'h00);
`else
        applyStimulus(8'h43, 1'b1, 1'b1);
        @(negedge clk_50);
        checkOutput("c_pops", 32'(popCount - pc0), 32'd1);
        checkOutput("c_cmd", 32'(popLog[pc0]), 32'd5);
        checkOutput("c_valid_cycles", 32'(validCycles - vc0), 32'd1);
        checkOutput("c_rx_byte", 32'(rx_byte), 32'h43);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
